// File: rtl/decoded_instr_fifo.sv
// ============================================================================
//  Module   : decoded_instr_fifo
//  Purpose  : Circular queue of decoded instructions between the decoder and
//             the load/store reorder stage. Caps the number of control-flow
//             instructions held at once.
//  Option   : DECODED_FIFO_BYPASS_EN - when defined, an empty queue forwards
//             the decoder input to the issue outputs in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ariane_pkg;
  // Compact decoded-instruction record carried through the queue.
  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
  } scoreboard_entry_t;
endpackage

module decoded_instr_fifo #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MAX_CTRL_FLOW = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  ariane_pkg::scoreboard_entry_t   decoded_entry_i,
  input  logic                            decoded_valid_i,
  input  logic                            decoded_is_ctrl_flow_i,
  output logic                            decoded_ack_o,
  output ariane_pkg::scoreboard_entry_t   issue_entry_o,
  output logic                            issue_entry_valid_o,
  output logic                            is_ctrl_flow_o,
  input  logic                            issue_instr_ack_i,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CTRL_MAX = CW'(MAX_CTRL_FLOW);

  ariane_pkg::scoreboard_entry_t mem [DEPTH];
  logic [DEPTH-1:0] mem_ctrl;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count, ctrl_cnt;

  logic push, pop, wr_en, stored_valid, bypass_take, bypass_active;

  // Acceptance depends only on registered occupancy plus the decoder's own
  // flags, never on the downstream ack, so a full queue refuses even when
  // it is being drained in the same cycle.
  always_comb begin
    decoded_ack_o = 1'b1;
    if (count == FULL_CNT) decoded_ack_o = 1'b0;
    if (decoded_is_ctrl_flow_i && (ctrl_cnt == CTRL_MAX)) decoded_ack_o = 1'b0;
    if (flush_i) decoded_ack_o = 1'b0;
  end

  // Head selection, handshakes and the optional same-cycle bypass path.
  always_comb begin
    push          = decoded_valid_i & decoded_ack_o;
    stored_valid  = (count != '0) & ~flush_i;
    bypass_active = 1'b0;
    bypass_take   = 1'b0;
`ifdef DECODED_FIFO_BYPASS_EN
    bypass_active = (count == '0) & ~flush_i & decoded_valid_i;
    bypass_take   = bypass_active & push & issue_instr_ack_i;
`endif
    issue_entry_valid_o = stored_valid | bypass_active;
    issue_entry_o       = bypass_active ? decoded_entry_i : mem[rd_ptr];
    is_ctrl_flow_o      = bypass_active ? decoded_is_ctrl_flow_i : (stored_valid & mem_ctrl[rd_ptr]);
    // A bypassed entry that is consumed immediately is never stored.
    wr_en = push & ~bypass_take;
    pop   = stored_valid & issue_instr_ack_i;
    count_o = count;
  end

  // Storage, pointers and occupancy counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      mem_ctrl <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ctrl_cnt <= '0;
    end else if (flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ctrl_cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr]      <= decoded_entry_i;
        mem_ctrl[wr_ptr] <= decoded_is_ctrl_flow_i;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(wr_en) - CW'(pop);
      ctrl_cnt <= ctrl_cnt + CW'(wr_en & decoded_is_ctrl_flow_i)
                           - CW'(pop & mem_ctrl[rd_ptr]);
    end
  end

`ifndef SYNTHESIS
  // Simulation-only invariants on occupancy and the control-flow cap.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (count == FULL_CNT)));
  a_count_bound:  assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= FULL_CNT);
  a_ctrl_bound:   assert property (@(posedge clk_i) disable iff (!rst_ni)
    ctrl_cnt <= CTRL_MAX);
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoded_instr_fifo.sv
// ============================================================================
//  Module   : tb_decoded_instr_fifo
//  Purpose  : Directed self-checking bench for decoded_instr_fifo using a
//             reference queue model as scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoded_instr_fifo;

  localparam int DEPTH = 4;
  localparam int MAXC  = 1;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;
  ariane_pkg::scoreboard_entry_t decoded_entry_i;
  logic decoded_valid_i = 1'b0;
  logic decoded_is_ctrl_flow_i = 1'b0;
  logic decoded_ack_o;
  ariane_pkg::scoreboard_entry_t issue_entry_o;
  logic issue_entry_valid_o;
  logic is_ctrl_flow_o;
  logic issue_instr_ack_i = 1'b0;
  logic [$clog2(DEPTH):0] count_o;

  decoded_instr_fifo #(.DEPTH(DEPTH), .MAX_CTRL_FLOW(MAXC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .decoded_entry_i(decoded_entry_i), .decoded_valid_i(decoded_valid_i),
    .decoded_is_ctrl_flow_i(decoded_is_ctrl_flow_i), .decoded_ack_o(decoded_ack_o),
    .issue_entry_o(issue_entry_o), .issue_entry_valid_o(issue_entry_valid_o),
    .is_ctrl_flow_o(is_ctrl_flow_o), .issue_instr_ack_i(issue_instr_ack_i),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [63:0] pc; logic ctrl; } item_t;
  item_t sb[$];
  int    mctrl = 0;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, check outputs against the model,
  // advance the model on the edge.
  task automatic cycle(input logic v, input logic c, input logic [63:0] pc,
                       input logic ack, input logic fl);
    logic  exp_ack, exp_valid, byp, do_push, do_pop;
    logic [63:0] exp_pc;
    logic  exp_ctrl;
    item_t it;
    decoded_entry_i        = '0;
    decoded_entry_i.pc     = pc;
    decoded_valid_i        = v;
    decoded_is_ctrl_flow_i = c;
    issue_instr_ack_i      = ack;
    flush_i                = fl;
    #1;
    exp_ack = !(sb.size() == DEPTH) && !(c && mctrl == MAXC) && !fl;
    byp = 1'b0;
`ifdef DECODED_FIFO_BYPASS_EN
    byp = (sb.size() == 0) && !fl && v;
`endif
    exp_valid = byp || (sb.size() != 0 && !fl);
    chk("ack", 64'(decoded_ack_o), 64'(exp_ack));
    chk("valid", 64'(issue_entry_valid_o), 64'(exp_valid));
    chk("count", 64'(count_o), 64'(sb.size()));
    if (exp_valid) begin
      exp_pc   = byp ? pc : sb[0].pc;
      exp_ctrl = byp ? c : sb[0].ctrl;
      chk("head_pc", issue_entry_o.pc, exp_pc);
      chk("head_ctrl", 64'(is_ctrl_flow_o), 64'(exp_ctrl));
    end
    do_push = v && exp_ack;
    do_pop  = exp_valid && ack;
    @(posedge clk_i);
    if (fl) begin
      sb.delete();
      mctrl = 0;
    end else if (byp && do_push && do_pop) begin
      // consumed straight through, nothing stored
    end else begin
      if (do_pop && sb.size() != 0) begin
        it = sb.pop_front();
        if (it.ctrl) mctrl--;
      end
      if (do_push) begin
        it.pc = pc; it.ctrl = c;
        sb.push_back(it);
        if (c) mctrl++;
      end
    end
    #1;
  endtask

  initial begin
    decoded_entry_i = '0;
    // Reset state
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    chk("rst_ack", 64'(decoded_ack_o), 64'd1);
    chk("rst_valid", 64'(issue_entry_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_entry", issue_entry_o.pc, 64'd0);
    chk("rst_ctrl", 64'(is_ctrl_flow_o), 64'd0);
    cycle(0, 0, 0, 0, 0);

    // Fill with four non-ctrl entries, probe full, then drain in order
    for (int i = 0; i < 4; i++) cycle(1, 0, 64'h80 + 64'(4 * i), 0, 0);
    chk("full_count", 64'(count_o), 64'd4);
    cycle(1, 0, 64'h90, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    chk("drained", 64'(count_o), 64'd0);

    // Control-flow cap: second branch refused, non-ctrl accepted meanwhile
    cycle(1, 1, 64'h200, 0, 0);
    cycle(1, 1, 64'h204, 0, 0);
    cycle(1, 0, 64'h208, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("cap_count", 64'(count_o), 64'd2);
    cycle(1, 1, 64'h204, 1, 0);
    cycle(1, 1, 64'h204, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

    // Full with simultaneous push and pop: push refused
    for (int i = 0; i < 4; i++) cycle(1, 0, 64'h300 + 64'(4 * i), 0, 0);
    cycle(1, 0, 64'h310, 1, 0);
    chk("fullpp_count", 64'(count_o), 64'd3);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

    // Flush with a branch held, then a new branch is accepted
    cycle(1, 0, 64'h400, 0, 0);
    cycle(1, 1, 64'h404, 0, 0);
    cycle(1, 0, 64'h408, 0, 0);
    cycle(1, 1, 64'h40C, 1, 1);
    chk("flush_count", 64'(count_o), 64'd0);
    cycle(1, 1, 64'h500, 0, 0);
    cycle(0, 0, 0, 1, 0);

    // Asynchronous reset mid-operation
    cycle(1, 0, 64'h600, 0, 0);
    cycle(1, 1, 64'h604, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_valid", 64'(issue_entry_valid_o), 64'd0);
    sb.delete();
    mctrl = 0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    cycle(1, 0, 64'h700, 0, 0);
    cycle(0, 0, 0, 1, 0);

`ifdef DECODED_FIFO_BYPASS_EN
    // Same-cycle bypass on an empty queue
    cycle(1, 0, 64'h100, 1, 0);
    chk("byp_count", 64'(count_o), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decoded_instr_fifo.md
Name: decoded_instr_fifo

Overview:
- Small circular queue of decoded instructions between the decoder and the load/store reorder stage.
- Decouples decode from issue back-pressure so the reorder stage sees a steady stream of candidates.
- Caps the number of in-flight control-flow instructions to limit wasted fetch on misprediction.
- Produces issue_entry / issue_entry_valid / is_ctrl_flow and consumes the issue ack of the downstream reorder stage.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- MAX_CTRL_FLOW, 1: maximum control-flow entries held at once; range 1..DEPTH.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- flush_i  input  1  discard all entries; takes effect at next clock edge.
- decoded_entry_i  input  ariane_pkg::scoreboard_entry_t  instruction from decoder.
- decoded_valid_i  input  1  decoder offers decoded_entry_i.
- decoded_is_ctrl_flow_i  input  1  offered instruction is branch/jump.
- decoded_ack_o  output  1  entry accepted this cycle (push = decoded_valid_i & decoded_ack_o).
- issue_entry_o  output  ariane_pkg::scoreboard_entry_t  head entry.
- issue_entry_valid_o  output  1  head entry valid.
- is_ctrl_flow_o  output  1  head entry is control flow.
- issue_instr_ack_i  input  1  downstream consumed head (pop = issue_entry_valid_o & issue_instr_ack_i).
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - entry array with per-entry ctrl-flow bit;
  - rd_ptr and wr_ptr, $clog2(DEPTH) bits each, wrapping modulo DEPTH;
  - count, 0..DEPTH;
  - ctrl_cnt, 0..MAX_CTRL_FLOW.
- Reset: pointers, count and ctrl_cnt are 0 and all entries cleared. Resulting outputs:
  - issue_entry_o = '0
  - issue_entry_valid_o = 0
  - is_ctrl_flow_o = 0
  - decoded_ack_o = 1
  - count_o = 0
- decoded_ack_o is computed from registered state only, with no combinational path from issue_instr_ack_i. It is low when any of these hold:
  - count == DEPTH;
  - decoded_is_ctrl_flow_i & (ctrl_cnt == MAX_CTRL_FLOW);
  - flush_i.
- Push: write decoded_entry_i at wr_ptr, wr_ptr++, count++, ctrl_cnt++ if ctrl flow.
- Output: issue_entry_valid_o = (count != 0) & !flush_i; head = entry[rd_ptr].
- Pop: rd_ptr++, count--, ctrl_cnt-- if head is ctrl flow.
- Latency: 1 cycle from push to head visibility when the queue is empty.
- Simultaneous push and pop:
  - count is unchanged;
  - ctrl_cnt is updated by (push_ctrl - pop_ctrl);
  - when full, no push occurs that cycle even if a pop does.
- Full with a ctrl limit reached: non-ctrl instructions are still accepted while count < DEPTH.
- Flush:
  - pointers, count and ctrl_cnt return to 0 at the next edge;
  - during the flush cycle no push and no valid output;
  - any pending pop that cycle is ignored.
- Reset asserted mid-operation: immediate return to reset state; entries are discarded.
- Ordering is strict FIFO; no reordering in this block.
- Assertions (simulation only):
  - no push when full;
  - count never exceeds DEPTH;
  - ctrl_cnt never exceeds MAX_CTRL_FLOW.

Optional Feature:
- Macro: DECODED_FIFO_BYPASS_EN.
- Defined:
  - when count == 0 and not flushing, the decoder input passes straight to the outputs in the same cycle (issue_entry_valid_o = decoded_valid_i);
  - if issue_instr_ack_i is also high, the entry is consumed without being written and ctrl_cnt is unchanged;
  - otherwise it is written normally;
  - decoded_ack_o rules are unchanged.
- Undefined: 1-cycle latency through storage as described above.

Test Plan:
- Reset release, no input -> decoded_ack_o=1, issue_entry_valid_o=0, count_o=0.
- Push 4 non-ctrl entries (pc 0x80,0x84,0x88,0x8C) with issue_instr_ack_i=0 -> count_o=4, decoded_ack_o=0; then ack 4 cycles -> pcs emerge in order 0x80..0x8C, count_o=0.
- MAX_CTRL_FLOW=1: push branch, then offer second branch -> decoded_ack_o=0 until branch popped; a non-ctrl offered meanwhile -> accepted, count_o=2.
- Full (count_o=4), push and pop same cycle -> pop occurs, push refused, count_o=3 next cycle.
- Occupancy 3 incl. 1 branch, assert flush_i one cycle with decoded_valid_i=1 -> that cycle valid_o=0 and ack_o=0; next cycle count_o=0, ctrl_cnt=0, a new branch is accepted.
- With DECODED_FIFO_BYPASS_EN, empty, push pc 0x100 with issue_instr_ack_i=1 -> issue_entry_o.pc=0x100, valid same cycle, count_o stays 0.
